// File: rtl/wb_pkg.sv
// Shared types and constants for the GRF write-port arbiter.
package wb_pkg;

  localparam int unsigned PC_W   = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 32;

  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              live;
  } wb_entry_t;

endpackage

// File: rtl/wb_late_fifo.sv
// Storage and pointers for buffered late (MDU/CP0) register writes.
module wb_late_fifo
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  wb_entry_t         push_entry,
  input  logic              pop,
  input  logic              squash,
  input  logic [ADDR_W-1:0] squash_addr,
  output wb_entry_t         head,
  output logic              empty,
  output logic              full,
  output logic              any_live
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  wb_entry_t          mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

  // Popped slots drop their live bit so any_live reflects only resident entries.
  always_comb begin
    any_live = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      any_live = any_live | mem[i].live;
    end
  end

  // Squash hits resident entries only; the slot being pushed is written last.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (squash && mem[i].live && (mem[i].addr == squash_addr)) begin
          mem[i].live <= 1'b0;
        end
      end
      if (pop) begin
        mem[rd_ptr].live <= 1'b0;
        rd_ptr           <= rd_ptr + PTR_W'(1);
      end
      if (push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single GRF write port between the W stage and buffered late writes.
// Optional trace output is enabled by defining WB_ARB_TRACE_EN.
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              w_we,
  input  logic [PC_W-1:0]   w_pc,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [PC_W-1:0]   s_pc,
  input  logic [ADDR_W-1:0] s_addr,
  input  logic [DATA_W-1:0] s_data,
  output logic              stall_w,
  output logic              grf_we,
  output logic [PC_W-1:0]   grf_pc,
  output logic [ADDR_W-1:0] grf_addr,
  output logic [DATA_W-1:0] grf_data,
  output logic              pending
);

  localparam int unsigned SC_W = $clog2(STARVE_LIMIT + 1);

  wb_entry_t        head;
  wb_entry_t        push_entry;
  logic             fifo_empty;
  logic             fifo_full;
  logic             any_live;
  logic             push;
  logic             pop;
  logic             w_eff;
  logic             head_wr;
  logic [SC_W-1:0]  starve_cnt;

  assign push_entry = '{pc: s_pc, addr: s_addr, data: s_data, live: 1'b1};

  assign s_ready = !fifo_full;
  assign push    = s_valid && s_ready;
  assign stall_w = !fifo_empty && head.live && (starve_cnt == SC_W'(STARVE_LIMIT));
  assign w_eff   = reset && w_we && (w_addr != REG_ZERO) && !stall_w;
  assign pop     = reset && !w_eff && !fifo_empty;
  assign head_wr = pop && head.live && (head.addr != REG_ZERO);
  assign pending = any_live;

  wb_late_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push        (push),
    .push_entry  (push_entry),
    .pop         (pop),
    .squash      (w_eff),
    .squash_addr (w_addr),
    .head        (head),
    .empty       (fifo_empty),
    .full        (fifo_full),
    .any_live    (any_live)
  );

  // W stage has priority; the buffered head only gets idle port cycles.
  always_comb begin
    grf_we   = 1'b0;
    grf_pc   = '0;
    grf_addr = '0;
    grf_data = '0;
    if (w_eff) begin
      grf_we   = 1'b1;
      grf_pc   = w_pc;
      grf_addr = w_addr;
      grf_data = w_data;
    end else if (head_wr) begin
      grf_we   = 1'b1;
      grf_pc   = head.pc;
      grf_addr = head.addr;
      grf_data = head.data;
    end
  end

  // Counts how long a waiting head has been denied the port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (pop || fifo_empty) begin
      starve_cnt <= '0;
    end else if (starve_cnt != SC_W'(STARVE_LIMIT)) begin
      starve_cnt <= starve_cnt + SC_W'(1);
    end
  end

`ifdef WB_ARB_TRACE_EN
  always_ff @(posedge clk) begin
    if (grf_we) begin
      $display("@%h: $%d <= %h", grf_pc, grf_addr, grf_data);
    end
  end
`else
  // Trace disabled: no simulation output.
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: expected GRF writes are queued by the stimulus.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        w_we;
  logic [31:0] w_pc;
  logic [4:0]  w_addr;
  logic [31:0] w_data;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_pc;
  logic [4:0]  s_addr;
  logic [31:0] s_data;
  logic        stall_w;
  logic        grf_we;
  logic [31:0] grf_pc;
  logic [4:0]  grf_addr;
  logic [31:0] grf_data;
  logic        pending;

  int total = 0;
  int bad   = 0;

  logic [68:0] exp_q [$];
  logic [31:0] regs [32];

  always #5 clk = ~clk;

  wb_port_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .w_we     (w_we),
    .w_pc     (w_pc),
    .w_addr   (w_addr),
    .w_data   (w_data),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_pc     (s_pc),
    .s_addr   (s_addr),
    .s_data   (s_data),
    .stall_w  (stall_w),
    .grf_we   (grf_we),
    .grf_pc   (grf_pc),
    .grf_addr (grf_addr),
    .grf_data (grf_data),
    .pending  (pending)
  );

  function automatic void chk(string name, logic [68:0] act, logic [68:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endfunction

  function automatic void exp_write(logic [31:0] pc, logic [4:0] a, logic [31:0] d);
    exp_q.push_back({pc, a, d});
  endfunction

  // Drive one cycle of inputs just after the rising edge.
  task automatic step(input logic wwe, input logic [31:0] wpc, input logic [4:0] wa,
                      input logic [31:0] wd, input logic sv, input logic [31:0] spc,
                      input logic [4:0] sa, input logic [31:0] sd);
    @(posedge clk);
    #1;
    w_we = wwe; w_pc = wpc; w_addr = wa; w_data = wd;
    s_valid = sv; s_pc = spc; s_addr = sa; s_data = sd;
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 5'd0, 32'h0, 1'b0, 32'h0, 5'd0, 32'h0);
  endtask

  // Monitor: every port write must match the head of the expected queue.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (grf_we) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: got %h/%0d/%h want none", grf_pc, grf_addr, grf_data);
        end else begin
          chk("grf_write", {grf_pc, grf_addr, grf_data}, exp_q.pop_front());
        end
        regs[grf_addr] = grf_data;
      end else begin
        chk("grf_idle", {grf_pc, grf_addr, grf_data}, 69'h0);
      end
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'h0;
    reset = 1'b0;
    w_we = 0; w_pc = 0; w_addr = 0; w_data = 0;
    s_valid = 0; s_pc = 0; s_addr = 0; s_data = 0;
    #3;
    chk("rst_s_ready", s_ready, 1);
    chk("rst_stall_w", stall_w, 0);
    chk("rst_pending", pending, 0);
    chk("rst_grf_we", grf_we, 0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;

    // Basic push, written one cycle later.
    step(1'b0, 32'h0, 5'd0, 32'h0, 1'b1, 32'h3000, 5'd5, 32'h11);
    @(negedge clk);
    chk("push_pending_pre", pending, 0);
    idle();
    exp_write(32'h3000, 5'd5, 32'h11);
    @(negedge clk);
    chk("push_pending_live", pending, 1);
    idle();
    @(negedge clk);
    chk("push_pending_drop", pending, 0);

    // Starvation: W busy on $3 for 10 cycles with one entry buffered.
    step(1'b0, 32'h0, 5'd0, 32'h0, 1'b1, 32'h3004, 5'd9, 32'h99);
    for (int k = 1; k <= 10; k++) begin
      step(1'b1, 32'h4000 + 32'(4 * k), 5'd3, 32'h30 + 32'(k), 1'b0, 32'h0, 5'd0, 32'h0);
      if (k == 5) exp_write(32'h3004, 5'd9, 32'h99);
      else        exp_write(32'h4000 + 32'(4 * k), 5'd3, 32'h30 + 32'(k));
      @(negedge clk);
      chk("starve_stall_w", stall_w, (k == 5) ? 1 : 0);
    end
    idle();

    // Squash: buffered $7 overtaken by a W write to $7.
    step(1'b0, 32'h0, 5'd0, 32'h0, 1'b1, 32'h3008, 5'd7, 32'hA);
    step(1'b1, 32'h5000, 5'd7, 32'hB, 1'b0, 32'h0, 5'd0, 32'h0);
    exp_write(32'h5000, 5'd7, 32'hB);
    idle();
    @(negedge clk);
    chk("squash_pending", pending, 0);
    idle();
    @(negedge clk);
    chk("squash_reg7", regs[7], 32'hB);

    // Full buffer: simultaneous pop and push is refused.
    step(1'b1, 32'h5004, 5'd2, 32'h21, 1'b1, 32'h300C, 5'd10, 32'hA1);
    exp_write(32'h5004, 5'd2, 32'h21);
    step(1'b1, 32'h5008, 5'd2, 32'h22, 1'b1, 32'h3010, 5'd11, 32'hA2);
    exp_write(32'h5008, 5'd2, 32'h22);
    @(negedge clk);
    chk("full_s_ready_one", s_ready, 1);
    step(1'b0, 32'h0, 5'd0, 32'h0, 1'b1, 32'h3014, 5'd12, 32'hA3);
    exp_write(32'h300C, 5'd10, 32'hA1);
    @(negedge clk);
    chk("full_s_ready_two", s_ready, 0);
    idle();
    exp_write(32'h3010, 5'd11, 32'hA2);
    @(negedge clk);
    chk("full_s_ready_after", s_ready, 1);
    idle();
    @(negedge clk);
    chk("full_pending_end", pending, 0);

    // W to $0 leaves the port to the head; a push to $0 pops silently.
    step(1'b0, 32'h0, 5'd0, 32'h0, 1'b1, 32'h3020, 5'd15, 32'hC1);
    step(1'b1, 32'h500C, 5'd0, 32'hDEAD, 1'b1, 32'h3024, 5'd0, 32'hC2);
    exp_write(32'h3020, 5'd15, 32'hC1);
    idle();
    @(negedge clk);
    chk("zero_pending_live", pending, 1);
    idle();
    @(negedge clk);
    chk("zero_pending_drop", pending, 0);
    chk("zero_reg0", regs[0], 32'h0);

    // Reset mid-operation with two entries buffered.
    step(1'b1, 32'h5010, 5'd4, 32'h41, 1'b1, 32'h3028, 5'd13, 32'hB1);
    exp_write(32'h5010, 5'd4, 32'h41);
    step(1'b1, 32'h5014, 5'd4, 32'h42, 1'b1, 32'h302C, 5'd14, 32'hB2);
    exp_write(32'h5014, 5'd4, 32'h42);
    @(posedge clk);
    #1;
    w_we = 0; w_addr = 0; w_data = 0; w_pc = 0; s_valid = 0;
    reset = 1'b0;
    #1;
    chk("midrst_pending", pending, 0);
    chk("midrst_s_ready", s_ready, 1);
    chk("midrst_stall_w", stall_w, 0);
    chk("midrst_grf_we", grf_we, 0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    repeat (4) idle();
    @(negedge clk);
    chk("midrst_reg13", regs[13], 32'h0);
    chk("midrst_reg14", regs[14], 32'h0);
    chk("refused_reg12", regs[12], 32'h0);
    chk("exp_queue_empty", 69'(exp_q.size()), 69'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
